instr_fetch: RTL and testbench

- Producer end of the opcode/instruction interface that the main decoder consumes.
- Holds the PC and issues one instruction-memory read at a time over a request/response handshake with variable latency.
- Presents a valid instruction, its PC and PC+4 to the decode stage, and accepts the branch/jump redirect (PCSrc, PCTarget) back from the core.
- Sits between instruction memory and the maindec/datapath.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/instr_fetch.sv | 117 +++++++++++
 tb/tb_instr_fetch.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, the canonical NOP and the
// base opcode map consumed by the main decoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding imem read, holds the fetched
// instruction for decode and applies branch/jump and flush redirects.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] Instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;

    unique case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        if (flush) kill_d = 1'b1;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // A flush landing on the same cycle as the response kills it directly.
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = imem_rdata;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + FOUR;
            state_d    = S_HOLD;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (instr_ready) begin
          pc_d    = PCSrc ? (PCTarget & WORD_MASK) : pc_plus4_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_RESET;
    endcase

    if (flush) pc_d = flush_pc & WORD_MASK;

    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= XLEN'(NOP_INSTR);
      pc_out_q   <= RESET_PC;
      pc_plus4_q <= RESET_PC + FOUR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  // pc_q only moves outside S_REQ, so it doubles as the request address.
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign Instr       = instr_q;
  assign op          = instr_q[6:0];
  assign PC          = pc_out_q;
  assign PCPlus4     = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a variable-latency instruction memory model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instr(Instr), .op(op), .PC(PC), .PCPlus4(PCPlus4),
    .PCSrc(PCSrc), .PCTarget(PCTarget),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 7) | 32'h0000_0093;
  endfunction

  // Memory: each request answered mem_lat cycles later; survives DUT reset.
  int          pend_cnt[$];
  logic [31:0] pend_addr[$];
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      for (int i = 0; i < pend_cnt.size(); i++) pend_cnt[i] = pend_cnt[i] - 1;
      if (pend_cnt.size() > 0 && pend_cnt[0] <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr[0]);
        void'(pend_cnt.pop_front());
        void'(pend_addr.pop_front());
      end
      if (imem_req) begin
        pend_cnt.push_back(mem_lat);
        pend_addr.push_back(imem_addr);
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < 50) begin
      wait_cycle();
      cyc++;
    end
    if (!instr_valid) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_ready = 1'b1; PCSrc = 1'b0; PCTarget = '0;
    flush = 1'b0; flush_pc = '0;
    repeat (3) wait_cycle();
    n_checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_valid: got %b expected 00", {imem_req, instr_valid});
    end
    n_checks++;
    if (Instr !== 32'h13 || op !== 7'h13) begin
      n_fail++; $display("FAIL reset_instr: got %h/%h expected 00000013/13", Instr, op);
    end
    n_checks++;
    if ({imem_addr, PC, PCPlus4} !== {32'h0, 32'h0, 32'h4}) begin
      n_fail++; $display("FAIL reset_pcs: got %h %h %h expected 0 0 4", imem_addr, PC, PCPlus4);
    end
  endtask

  task automatic test_first_fetch();
    mem_lat = 1;
    rst_n = 1'b1;
    wait_cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: got %b @%h expected 1 @0", imem_req, imem_addr);
    end
    wait_cycle();
    n_checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      n_fail++; $display("FAIL first_wait: got %b expected 00", {imem_req, instr_valid});
    end
    wait_cycle();
    n_checks++;
    if (instr_valid !== 1'b1 || Instr !== 32'h93 || op !== 7'h13 || PC !== 32'h0 || PCPlus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL first_deliver: got v=%b %h op=%h pc=%h p4=%h expected 1 00000093 13 0 4",
               instr_valid, Instr, op, PC, PCPlus4);
    end
    wait_cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL seq_req: got %b @%h v=%b expected 1 @4 v=0", imem_req, imem_addr, instr_valid);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_branch();
    int cyc;
    wait_valid(cyc);
    n_checks++;
    if (cyc < 0 || PC !== 32'h4 || PCPlus4 !== 32'h8 || Instr !== mem_word(32'h4)) begin
      n_fail++; $display("FAIL seq_deliver: got cyc=%0d pc=%h p4=%h i=%h expected pc=4 p4=8", cyc, PC, PCPlus4, Instr);
    end
    PCSrc = 1'b1; PCTarget = 32'h0000_0102; instr_ready = 1'b1;
    wait_cycle();
    instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = 32'hDEAD_BEEF;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL branch_req: got %b @%h expected 1 @00000100", imem_req, imem_addr);
    end
    wait_valid(cyc);
    n_checks++;
    if (cyc != 2 || PC !== 32'h100 || PCPlus4 !== 32'h104 || Instr !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL branch_deliver: got cyc=%0d pc=%h p4=%h i=%h expected cyc=2 pc=100 p4=104",
                         cyc, PC, PCPlus4, Instr);
    end
  endtask

  task automatic test_stall();
    int reqs = 0;
    int bad  = 0;
    for (int i = 0; i < 5; i++) begin
      PCSrc = 1'b1; PCTarget = 32'h0000_0400 + 32'(i);
      wait_cycle();
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || PC !== 32'h100 || Instr !== mem_word(32'h100)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad);
    end
    PCSrc = 1'b0; instr_ready = 1'b1;
    wait_cycle();
    instr_ready = 1'b0;
    if (imem_req === 1'b1) reqs++;
    n_checks++;
    if (imem_addr !== 32'h104 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got @%h v=%b expected @00000104 v=0", imem_addr, instr_valid);
    end
    for (int i = 0; i < 4; i++) begin
      wait_cycle();
      if (imem_req === 1'b1) reqs++;
    end
    n_checks++;
    if (reqs != 1) begin
      n_fail++; $display("FAIL stall_one_req: got %0d requests expected 1", reqs);
    end
  endtask

  task automatic test_flush_wait();
    int cyc;
    int n = 0;
    int leaked = 0;
    wait_valid(cyc);
    mem_lat = 4;
    instr_ready = 1'b1;
    wait_cycle();
    instr_ready = 1'b0;
    wait_cycle();
    flush = 1'b1; flush_pc = 32'h80;
    wait_cycle();
    flush = 1'b0; flush_pc = 32'hFFFF_0000;
    while (imem_req !== 1'b1 && n < 20) begin
      wait_cycle();
      n++;
      if (instr_valid === 1'b1) leaked++;
    end
    n_checks++;
    if (n != 3 || imem_addr !== 32'h80 || leaked != 0) begin
      n_fail++; $display("FAIL flush_wait_req: got after %0d cycles @%h leaked=%0d expected 3 @00000080 0",
                         n, imem_addr, leaked);
    end
    wait_valid(cyc);
    n_checks++;
    if (cyc != 5 || PC !== 32'h80 || Instr !== mem_word(32'h80)) begin
      n_fail++; $display("FAIL flush_wait_deliver: got cyc=%0d pc=%h i=%h expected 5 80 %h",
                         cyc, PC, Instr, mem_word(32'h80));
    end
  endtask

  task automatic test_flush_hold_wrap();
    int cyc;
    flush = 1'b1; flush_pc = 32'hFFFF_FFFF; instr_ready = 1'b1; PCSrc = 1'b1; PCTarget = 32'h200;
    wait_cycle();
    flush = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0;
    mem_lat = 1;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL flush_hold: got v=%b req=%b @%h expected 0 1 @fffffffc", instr_valid, imem_req, imem_addr);
    end
    wait_valid(cyc);
    n_checks++;
    if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0 || Instr !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL top_deliver: got pc=%h p4=%h expected fffffffc 0", PC, PCPlus4);
    end
    instr_ready = 1'b1;
    wait_cycle();
    instr_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_req: got %b @%h expected 1 @0", imem_req, imem_addr);
    end
    wait_valid(cyc);
    n_checks++;
    if (cyc < 0 || PC !== 32'h0 || PCPlus4 !== 32'h4) begin
      n_fail++; $display("FAIL wrap_deliver: got cyc=%0d pc=%h p4=%h expected pc=0 p4=4", cyc, PC, PCPlus4);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    int n = 0;
    int bad = 0;
    mem_lat = 4;
    PCSrc = 1'b1; PCTarget = 32'h40; instr_ready = 1'b1;
    wait_cycle();
    PCSrc = 1'b0; instr_ready = 1'b0;
    wait_cycle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid} !== 2'b00 || imem_addr !== 32'h0 || Instr !== 32'h13 || PCPlus4 !== 32'h4) begin
      n_fail++; $display("FAIL async_reset: got req=%b v=%b @%h i=%h p4=%h expected 0 0 @0 13 4",
                         imem_req, instr_valid, imem_addr, Instr, PCPlus4);
    end
    while (imem_rvalid !== 1'b1 && n < 10) begin
      @(posedge clk); #2;
      n++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (imem_rvalid !== 1'b1 || bad != 0) begin
      n_fail++; $display("FAIL stale_in_reset: got rvalid=%b bad=%0d expected 1 0", imem_rvalid, bad);
    end
    rst_n = 1'b1;
    wait_cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_req: got %b @%h v=%b expected 1 @0 v=0", imem_req, imem_addr, instr_valid);
    end
    wait_valid(cyc);
    n_checks++;
    if (cyc != 5 || PC !== 32'h0 || Instr !== 32'h93) begin
      n_fail++; $display("FAIL restart_deliver: got cyc=%0d pc=%h i=%h expected 5 0 00000093", cyc, PC, Instr);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_stall();
    test_flush_wait();
    test_flush_hold_wrap();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
